// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, data-memory wait, taken-branch flush.
// Optional per-cycle stall/flush statistics are enabled with `define HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_LAT = 3,
    parameter int unsigned REG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             exmem_memacc_i,
    input  logic             branch_taken_i,
    output logic             hd_o,
    output logic             ifid_hold_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             ifid_flush_o,
    output logic [31:0]      stall_cycles_o,
    output logic [31:0]      flush_count_o
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 32;
    localparam bit          MEM_EN = (MEM_LAT != 0);
    localparam bit          LAT_1  = (MEM_LAT == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MASK     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;

    logic active;
    logic luse;
    logic mreq;
    logic mem_stall;

    // Hazard inputs only matter once the CPU has been started and reset is released.
    assign active = rst_i & armed_q;
    assign luse   = idex_memread_i & (idex_rt_i != '0) &
                    ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    assign mreq      = active & exmem_memacc_i & MEM_EN & (state_q == ST_IDLE);
    assign mem_stall = mreq | (active & (state_q == ST_MEM_WAIT));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_d       = armed_q | start_i;
        hd_o          = 1'b0;
        ifid_hold_o   = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        ifid_flush_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mreq) begin
                    if (LAT_1) begin
                        state_d = ST_MASK;
                    end else begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_MASK;
                end
            end
            ST_MASK: begin
                // The stalled access completes here; a new access waits one cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Fixed priority: memory wait, then load-use, then taken branch.
        if (mem_stall) begin
            hd_o          = 1'b1;
            ifid_hold_o   = 1'b1;
            pipe_freeze_o = 1'b1;
        end else if (active && luse) begin
            hd_o          = 1'b1;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (active && branch_taken_i) begin
            ifid_flush_o  = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;
    logic [STAT_W-1:0] flush_q, flush_d;

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hd_o && (stall_q != '1)) begin
            stall_d = stall_q + STAT_W'(1);
        end
        if (ifid_flush_o && (flush_q != '1)) begin
            flush_d = flush_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by randomized traffic vs a reference model.
module tb_hazard_ctrl;

    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned REG_W   = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rt_i;
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic             exmem_memacc_i;
    logic             branch_taken_i;
    logic             hd_o;
    logic             ifid_hold_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic             ifid_flush_o;
    logic [31:0]      stall_cycles_o;
    logic [31:0]      flush_count_o;

    hazard_ctrl #(.MEM_LAT(MEM_LAT), .REG_W(REG_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .exmem_memacc_i (exmem_memacc_i),
        .branch_taken_i (branch_taken_i),
        .hd_o           (hd_o),
        .ifid_hold_o    (ifid_hold_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_freeze_o  (pipe_freeze_o),
        .ifid_flush_o   (ifid_flush_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: armed flag, frozen cycles still owed, and "access just finished" mask.
    bit          m_armed   = 1'b0;
    int          m_owed    = 0;
    bit          m_mask    = 1'b0;
    int unsigned m_stalls  = 0;
    int unsigned m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic cyc(input logic r, input logic s, input logic mr,
                       input logic [REG_W-1:0] irt, input logic [REG_W-1:0] irs,
                       input logic [REG_W-1:0] irt2, input logic acc, input logic br,
                       input string tag);
        logic [4:0] exp;
        bit         luse;
        bit         new_acc;
        @(negedge clk_i);
        rst_i = r; start_i = s; idex_memread_i = mr; idex_rt_i = irt;
        ifid_rs_i = irs; ifid_rt_i = irt2; exmem_memacc_i = acc; branch_taken_i = br;
        #1;
        luse    = mr && (irt != 0) && ((irt == irs) || (irt == irt2));
        new_acc = (m_owed == 0) && !m_mask && acc && (MEM_LAT > 0);
        // Expected vector order: {hd, hold, bubble, freeze, flush}
        if (!r || !m_armed)              exp = 5'b00000;
        else if (m_owed > 0 || new_acc)  exp = 5'b11010;
        else if (luse)                   exp = 5'b11100;
        else if (br)                     exp = 5'b00001;
        else                             exp = 5'b00000;
        check({tag, ".ctl"}, 32'({hd_o, ifid_hold_o, idex_bubble_o, pipe_freeze_o, ifid_flush_o}),
              32'(exp));
`ifdef HAZARD_STATS_EN
        check({tag, ".stall_cnt"}, stall_cycles_o, m_stalls);
        check({tag, ".flush_cnt"}, flush_count_o, m_flushes);
`else
        check({tag, ".stall_cnt"}, stall_cycles_o, 32'd0);
        check({tag, ".flush_cnt"}, flush_count_o, 32'd0);
`endif
        @(posedge clk_i);
        if (!r) begin
            m_armed = 1'b0; m_owed = 0; m_mask = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (exp[4]) m_stalls++;
            if (exp[0]) m_flushes++;
            if (m_armed) begin
                if (m_owed > 0) begin
                    m_owed--;
                    m_mask = (m_owed == 0);
                end else if (new_acc) begin
                    m_owed = int'(MEM_LAT) - 1;
                    m_mask = (m_owed == 0);
                end else begin
                    m_mask = 1'b0;
                end
            end
            m_armed = m_armed | s;
        end
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; idex_memread_i = 1'b0; idex_rt_i = '0;
        ifid_rs_i = '0; ifid_rt_i = '0; exmem_memacc_i = 1'b0; branch_taken_i = 1'b0;
        repeat (2) @(posedge clk_i);

        cyc(0, 0, 1, 8, 8, 0, 1, 1, "in_reset");
        // Pre-start: hazards ignored, including the start cycle itself
        cyc(1, 0, 1, 8, 8, 0, 0, 0, "prestart");
        cyc(1, 1, 1, 8, 8, 0, 0, 0, "start_cycle");
        cyc(1, 0, 1, 8, 8, 0, 0, 0, "armed_luse");
        // Load-use on rt, then rt=0 never stalls
        cyc(1, 0, 1, 9, 3, 9, 0, 0, "luse_rt");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, "luse_r0");
        // Memory wait: 3 frozen, MASK, then a fresh access freezes again
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, "memwait");
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, "drain");
        // Branch loses to load-use, then flushes alone
        cyc(1, 0, 1, 7, 7, 0, 0, 1, "br_luse");
        cyc(1, 0, 0, 7, 7, 0, 0, 1, "br_only");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "idle");
        // Reset in the second frozen cycle; no freeze afterwards without a new start
        cyc(1, 0, 0, 0, 0, 0, 1, 0, "pre_rst_freeze");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, "mid_rst");
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 5, 5, 5, 1, 1, "post_rst");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, "rearm");

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)),
                REG_W'($urandom_range(0, 3)),
                REG_W'($urandom_range(0, 3)),
                REG_W'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0),
                "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipeline; generates the stall (hd) and flush controls consumed by the PC register, the IF/ID and ID/EX pipeline registers, and the EX/MEM freeze.
- Covers three hazard sources: load-use stalls, multi-cycle data-memory waits (counter plus FSM), and taken-branch IF/ID flushes.
- Resolves these with a fixed priority.

Parameters:
- MEM_LAT, 3: total stall cycles per data-memory access; 0 disables memory-wait stalls; legal range 0..15.
- REG_W, 5: register-specifier width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  CPU start; same signal the PC register receives.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  REG_W  destination register of the ID/EX load.
- ifid_rs_i  in  REG_W  rs of the instruction in IF/ID.
- ifid_rt_i  in  REG_W  rt of the instruction in IF/ID.
- exmem_memacc_i  in  1  instruction in EX/MEM accesses data memory (load or store).
- branch_taken_i  in  1  branch resolved taken in ID.
- hd_o  out  1  hold PC (1 = PC keeps its value).
- ifid_hold_o  out  1  IF/ID keeps its contents.
- idex_bubble_o  out  1  zero ID/EX control fields (insert bubble).
- pipe_freeze_o  out  1  ID/EX and EX/MEM keep their contents; MEM/WB gets a bubble.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- stall_cycles_o  out  32  stall-cycle count (optional feature).
- flush_count_o  out  32  flush count (optional feature).

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - state=IDLE, cnt=0, armed=0, stat counters=0.
  - While rst_i=0, all outputs are forced 0 combinationally.
- Arming:
  - armed is set at the first edge where start_i=1 and is never cleared except by reset.
  - While armed=0, including the start cycle itself, all control outputs are 0 and hazard inputs are ignored.
- Control outputs are combinational from state plus inputs (Mealy). Stalls take effect at the same edge where the hazard is detected.
- FSM states are IDLE, MEM_WAIT and MASK.
- Definition: luse = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- Definition: mreq = exmem_memacc_i & (MEM_LAT!=0) & state==IDLE.
- Priority per cycle, highest first:
  1. Memory stall (mreq or state==MEM_WAIT): hd_o=ifid_hold_o=pipe_freeze_o=1; idex_bubble_o=0; ifid_flush_o=0; luse and branch are ignored.
  2. luse: hd_o=ifid_hold_o=idex_bubble_o=1; ifid_flush_o=0 (the branch re-evaluates next cycle).
  3. branch_taken_i: ifid_flush_o=1 for exactly that cycle; hd_o=0.
  4. Otherwise all outputs are 0.
- IDLE transitions:
  - mreq and MEM_LAT==1 -> MASK.
  - mreq and MEM_LAT>1 -> MEM_WAIT with cnt=MEM_LAT-1.
  - Otherwise stay in IDLE.
- MEM_WAIT:
  - Freeze is asserted and cnt decrements every cycle.
  - At the edge where cnt==1 -> MASK.
  - Total frozen cycles = MEM_LAT exactly.
- MASK:
  - The stalled access completes in this cycle; exmem_memacc_i is ignored.
  - Priorities 2-4 apply normally.
  - Next state is always IDLE, so back-to-back accesses stall again one cycle later.
- The cnt width is 4 bits; no wrap is possible within the legal MEM_LAT range.
- Reset mid-MEM_WAIT: the FSM returns to IDLE and no residual freeze appears after reset deasserts. armed is cleared, so start_i is required again.
- hd_o must equal 1 whenever ifid_hold_o=1. ifid_flush_o and ifid_hold_o are never both 1.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - stall_cycles_o increments by 1 every cycle hd_o=1.
  - flush_count_o increments by 1 every cycle ifid_flush_o=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined: both ports are present, tied to 0, and no counter flops exist.

Test Plan:
- Pre-start: rst_i=1, start_i=0, idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> all outputs 0. Pulse start_i=1 -> still 0 that cycle; next cycle hd_o=ifid_hold_o=idex_bubble_o=1.
- Load-use: armed, lw writes $9 in ID/EX, ifid_rt_i=9 -> hd_o=ifid_hold_o=idex_bubble_o=1 for one cycle. With idex_rt_i=0, no stall.
- Memory wait, MEM_LAT=3: exmem_memacc_i held 1 for 4 cycles -> pipe_freeze_o=hd_o=1 for cycles 1-3, 0 in cycle 4 (MASK). A new access in cycle 5 freezes again.
- Branch plus load-use: luse=1 and branch_taken_i=1 -> ifid_flush_o=0, stall asserted. Next cycle branch_taken_i=1, luse=0 -> ifid_flush_o=1, hd_o=0.
- Reset mid-MEM_WAIT: rst_i=0 during the second frozen cycle -> outputs 0 immediately. After rst_i=1 with no start_i, outputs remain 0 despite exmem_memacc_i=1.
- With HAZARD_STATS_EN, MEM_LAT=3: one access plus one load-use plus two flushes -> stall_cycles_o=4, flush_count_o=2. Without the macro, both read 0.
